// File: rtl/hpam_div16x8_seq_if.sv
// Valid/ready operand and result bundle for the sequential 2W/W restoring divider.
// The master drives the operands and out_ready. The slave returns in_ready and the result.
interface hpam_div16x8_seq_if #(parameter int W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   quotient;
  logic [W-1:0]     remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/hpam_div16x8_seq.sv
// Unsigned restoring divider: a 2W-bit dividend over a W-bit divisor, one radix-2 step per clock.
// The result is held in registers behind a valid/ready handshake. A zero divisor short-circuits straight to DONE.
module hpam_div16x8_seq #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  hpam_div16x8_seq_if.slave   bus
);
  localparam int CW = $clog2(2*W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    r;     // working remainder; stays below the divisor, so W bits suffice
  logic [2*W-1:0]  q;
  logic [W-1:0]    dvs;

  logic [W:0]      t;
  logic            ge;

  assign t  = {r, q[2*W-1]};
  assign ge = (t >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      r               <= '0;
      q               <= '0;
      dvs             <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          bus.in_ready <= 1'b0;
          dvs          <= bus.divisor;
          if (bus.divisor == '0) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.quotient    <= '1;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b1;
          end else begin
            state <= BUSY;
            cnt   <= '0;
            r     <= '0;
            q     <= bus.dividend;
          end
        end
        BUSY: begin
          r   <= ge ? W'(t - {1'b0, dvs}) : t[W-1:0];
          q   <= {q[2*W-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(2*W-1)) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.quotient    <= {q[2*W-2:0], ge};
            bus.remainder   <= ge ? W'(t - {1'b0, dvs}) : t[W-1:0];
            bus.div_by_zero <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          // in_ready rises only after the result has left, so back-to-back ops never overlap
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
